// File: rtl/rx_udp_analy_core.sv
// UDP receive analyser: strips the 8-byte UDP header, forwards the payload with a
// fixed 4-clock latency, checks the destination port and the pseudo-header checksum.
module rx_udp_analy_core #(
    parameter int DATA_W = 32,
    parameter int IP_W   = 32,
    parameter int PORT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IP_W-1:0]   cfg_ip_local,
    input  logic [IP_W-1:0]   cfg_ip_pc,
    input  logic [PORT_W-1:0] cfg_port_local,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [1:0]        din_mty,
    input  logic              din_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [1:0]        dout_mty,
    output logic              dout_err,
    output logic              flag_port_local_err,
    output logic              flag_sum_err
);

    function automatic logic [DATA_W-1:0] mask_word(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] mty);
        case (mty)
            2'd1:    return {w[DATA_W-1:8], 8'h00};
            2'd2:    return {w[DATA_W-1:16], 16'h0000};
            2'd3:    return {w[DATA_W-1:24], 24'h000000};
            default: return w;
        endcase
    endfunction

    function automatic logic [15:0] fold16(input logic [31:0] s);
        logic [16:0] t;
        t = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    logic [DATA_W-1:0] data_p0, data_p1, data_p2;
    logic              vld_p0, sop_p0, eop_p0, err_p0;
    logic [1:0]        mty_p0, mty_p1, mty_p2;
    logic              vld_p1, sop_p1, eop_p1, err_p1, ckz_p1;
    logic [15:0]       sum_p1;
    logic              port_upd_p1, port_bad_p1;
    logic              vld_p2, sop_p2, eop_p2, err_p2, sum_err_p2;
    logic              port_upd_p2, port_bad_p2;

    logic [1:0]        idx;
    logic              in_pkt;
    logic [31:0]       acc;
    logic [15:0]       ck_field;
    logic              err_acc;

    logic [DATA_W-1:0] cw;
    logic [31:0]       pseudo, halves, acc_next;
    logic [1:0]        cur_idx;
    logic              take, payload, err_next;

    assign pseudo = 32'(cfg_ip_pc[31:16]) + 32'(cfg_ip_pc[15:0])
                  + 32'(cfg_ip_local[31:16]) + 32'(cfg_ip_local[15:0]) + 32'h0000_0011;

    always_comb begin
        cw       = eop_p0 ? mask_word(data_p0, mty_p0) : data_p0;
        halves   = {16'd0, cw[31:16]} + {16'd0, cw[15:0]};
        take     = vld_p0 && (sop_p0 || in_pkt);
        cur_idx  = sop_p0 ? 2'd0 : idx;
        // udp_length enters twice: once as a pseudo-header field, once as datagram data
        acc_next = (sop_p0 ? pseudo : acc) + halves
                 + ((cur_idx == 2'd1) ? {16'd0, cw[31:16]} : 32'd0);
        err_next = (sop_p0 ? 1'b0 : err_acc) | err_p0;
        payload  = take && (cur_idx >= 2'd2);
    end

    // stage 0: input capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
            sop_p0  <= 1'b0;
            eop_p0  <= 1'b0;
            mty_p0  <= 2'd0;
            err_p0  <= 1'b0;
        end else begin
            data_p0 <= din;
            vld_p0  <= din_vld;
            sop_p0  <= din_vld & din_sop;
            eop_p0  <= din_vld & din_eop;
            mty_p0  <= din_mty;
            err_p0  <= din_vld & din_err;
        end
    end

    // stage 1: header parse, checksum accumulation, payload selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= 2'd0;
            in_pkt      <= 1'b0;
            acc         <= '0;
            ck_field    <= '0;
            err_acc     <= 1'b0;
            data_p1     <= '0;
            vld_p1      <= 1'b0;
            sop_p1      <= 1'b0;
            eop_p1      <= 1'b0;
            mty_p1      <= 2'd0;
            err_p1      <= 1'b0;
            sum_p1      <= '0;
            ckz_p1      <= 1'b0;
            port_upd_p1 <= 1'b0;
            port_bad_p1 <= 1'b0;
        end else begin
            if (take) begin
                idx     <= (cur_idx == 2'd3) ? 2'd3 : 2'(cur_idx + 2'd1);
                in_pkt  <= !eop_p0;
                acc     <= acc_next;
                err_acc <= err_next;
                if (cur_idx == 2'd1)
                    ck_field <= cw[15:0];
            end
            data_p1     <= data_p0;
            vld_p1      <= payload;
            sop_p1      <= payload && (cur_idx == 2'd2);
            eop_p1      <= payload && eop_p0;
            mty_p1      <= (payload && eop_p0) ? mty_p0 : 2'd0;
            err_p1      <= err_next;
            sum_p1      <= fold16(acc_next);
            ckz_p1      <= (ck_field == 16'h0000);
            port_upd_p1 <= take && sop_p0;
            port_bad_p1 <= (data_p0[PORT_W-1:0] != cfg_port_local);
        end
    end

    // stage 2: checksum verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p2     <= '0;
            vld_p2      <= 1'b0;
            sop_p2      <= 1'b0;
            eop_p2      <= 1'b0;
            mty_p2      <= 2'd0;
            err_p2      <= 1'b0;
            sum_err_p2  <= 1'b0;
            port_upd_p2 <= 1'b0;
            port_bad_p2 <= 1'b0;
        end else begin
            data_p2     <= data_p1;
            vld_p2      <= vld_p1;
            sop_p2      <= sop_p1;
            eop_p2      <= eop_p1;
            mty_p2      <= mty_p1;
            sum_err_p2  <= eop_p1 && !ckz_p1 && (sum_p1 != 16'hFFFF);
            err_p2      <= eop_p1 && (err_p1 || (!ckz_p1 && (sum_p1 != 16'hFFFF)));
            port_upd_p2 <= port_upd_p1;
            port_bad_p2 <= port_bad_p1;
        end
    end

    // stage 3: output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout                <= '0;
            dout_vld            <= 1'b0;
            dout_sop            <= 1'b0;
            dout_eop            <= 1'b0;
            dout_mty            <= 2'd0;
            dout_err            <= 1'b0;
            flag_sum_err        <= 1'b0;
            flag_port_local_err <= 1'b0;
        end else begin
            dout         <= data_p2;
            dout_vld     <= vld_p2;
            dout_sop     <= sop_p2;
            dout_eop     <= eop_p2;
            dout_mty     <= mty_p2;
            dout_err     <= err_p2;
            flag_sum_err <= sum_err_p2;
            if (port_upd_p2)
                flag_port_local_err <= port_bad_p2;
        end
    end

endmodule

// File: tb/tb_rx_udp_analy_core.sv
// Scoreboard bench for rx_udp_analy_core: packets are driven by tasks, expected
// payload words and port-flag changes are queued with the cycle they must appear.
module tb_rx_udp_analy_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_ip_local, cfg_ip_pc;
    logic [15:0] cfg_port_local;
    logic [31:0] din;
    logic        din_vld, din_sop, din_eop, din_err;
    logic [1:0]  din_mty;
    logic [31:0] dout;
    logic        dout_vld, dout_sop, dout_eop, dout_err;
    logic [1:0]  dout_mty;
    logic        flag_port_local_err, flag_sum_err;

    rx_udp_analy_core #(.DATA_W(32), .IP_W(32), .PORT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_ip_local(cfg_ip_local), .cfg_ip_pc(cfg_ip_pc), .cfg_port_local(cfg_port_local),
        .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
        .din_mty(din_mty), .din_err(din_err),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_mty(dout_mty), .dout_err(dout_err),
        .flag_port_local_err(flag_port_local_err), .flag_sum_err(flag_sum_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sop, eop;
        logic [1:0]  mty;
        logic        err, serr;
        int          cyc;
    } exp_t;

    typedef struct {
        int   cyc;
        logic val;
    } pev_t;

    exp_t        sbq[$];
    pev_t        pq[$];
    exp_t        mon_e;
    logic        exp_port = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] pkt [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a payload word
    always @(negedge clk) begin
        if (rst) begin
            exp_port = 1'b0;
            sbq.delete();
            pq.delete();
        end else begin
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                exp_port = pq[0].val;
                pq.delete(0);
            end
            n_cmp++;
            if (flag_port_local_err !== exp_port) begin
                n_bad++;
                $display("FAIL port_flag cyc=%0d got %b expected %b", cyc, flag_port_local_err, exp_port);
            end
            if (dout_vld) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_dout cyc=%0d got %h expected no word", cyc, dout);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({dout, dout_sop, dout_eop, dout_mty, dout_err, flag_sum_err} !==
                        {mon_e.data, mon_e.sop, mon_e.eop, mon_e.mty, mon_e.err, mon_e.serr}) begin
                        n_bad++;
                        $display("FAIL dout_word cyc=%0d got data=%h sop=%b eop=%b mty=%0d err=%b sum_err=%b expected data=%h sop=%b eop=%b mty=%0d err=%b sum_err=%b",
                                 cyc, dout, dout_sop, dout_eop, dout_mty, dout_err, flag_sum_err,
                                 mon_e.data, mon_e.sop, mon_e.eop, mon_e.mty, mon_e.err, mon_e.serr);
                    end
                    n_cmp++;
                    if (cyc !== mon_e.cyc) begin
                        n_bad++;
                        $display("FAIL dout_latency got cyc=%0d expected cyc=%0d", cyc, mon_e.cyc);
                    end
                end
            end else if (flag_sum_err || dout_sop || dout_eop) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_strobe cyc=%0d got sum_err=%b sop=%b eop=%b expected 0", cyc, flag_sum_err, dout_sop, dout_eop);
            end
        end
    end

    function automatic bit model_fail(input int n, input logic [1:0] mty);
        logic [31:0] s;
        logic [31:0] w;
        s = 32'hC0A8 + 32'h010A + 32'hC0A8 + 32'h0109 + 32'h0011 + {16'd0, pkt[1][31:16]};
        for (int i = 0; i < n; i++) begin
            w = pkt[i];
            if (i == n - 1) w = w & (32'hFFFF_FFFF << (8 * mty));
            s = s + {16'd0, w[31:16]} + {16'd0, w[15:0]};
        end
        while ((s >> 16) != 0) s = (s & 32'h0000_FFFF) + (s >> 16);
        return !(pkt[1][15:0] == 16'h0000 || s[15:0] == 16'hFFFF);
    endfunction

    task automatic load_pkt(input logic [31:0] w0, input logic [31:0] w1);
        pkt[0] = w0;
        pkt[1] = w1;
        for (int i = 2; i < 8; i++) pkt[i] = 32'h0000_0001;
        pkt[8] = 32'h0000_0002;
    endtask

    task automatic send_pkt(input int n, input logic [1:0] mty, input int err_at,
                            input int gap_at, input bit trunc, input bit push);
        bit   fail, anyerr;
        exp_t e;
        pev_t p;
        fail   = model_fail(n, mty);
        anyerr = (err_at >= 0 && err_at < n);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                din_vld = 1'b0;
                repeat (2) @(negedge clk);
            end
            din     = pkt[i];
            din_vld = 1'b1;
            din_sop = (i == 0);
            din_eop = (i == n - 1) && !trunc;
            din_mty = din_eop ? mty : 2'd0;
            din_err = (i == err_at);
            if (push) begin
                if (i == 0) begin
                    p.cyc = cyc + 4;
                    p.val = (pkt[0][15:0] != 16'h1388);
                    pq.push_back(p);
                end
                if (i >= 2) begin
                    e.data = pkt[i];
                    e.sop  = (i == 2);
                    e.eop  = din_eop;
                    e.mty  = din_mty;
                    e.err  = din_eop && (fail || anyerr);
                    e.serr = din_eop && fail;
                    e.cyc  = cyc + 4;
                    sbq.push_back(e);
                end
            end
            @(negedge clk);
        end
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_err = 1'b0; din_mty = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 32'hDEAD_BEEF; din_vld = 1'b1; din_sop = 1'b1; din_eop = 1'b1; din_mty = 2'd3; din_err = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dout, dout_vld, dout_sop, dout_eop, dout_mty, dout_err, flag_port_local_err, flag_sum_err} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got dout=%h vld=%b sop=%b eop=%b mty=%0d err=%b port=%b sum=%b expected all 0",
                     dout, dout_vld, dout_sop, dout_eop, dout_mty, dout_err, flag_port_local_err, flag_sum_err);
        end
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 2'd0; din_err = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good();
        load_pkt(32'h0BB8_1388, 32'h0024_5CFC);
        send_pkt(9, 2'd2, -1, -1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL good_drain got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_wrong_port();
        load_pkt(32'h0BB8_1389, 32'h0024_5CF9);
        send_pkt(9, 2'd0, -1, -1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0 || flag_port_local_err !== 1'b1) begin
            n_bad++;
            $display("FAIL port_hold got pending=%0d flag=%b expected pending=0 flag=1", sbq.size(), flag_port_local_err);
        end
    endtask

    task automatic test_bad_sum();
        load_pkt(32'h0BB8_1388, 32'h0024_5CFB);
        send_pkt(9, 2'd0, -1, -1, 1'b0, 1'b1);
        load_pkt(32'h0BB8_1388, 32'h0024_0000);
        send_pkt(9, 2'd0, -1, -1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL bad_sum_drain got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        load_pkt(32'h0BB8_1388, 32'h0024_5CFC);
        send_pkt(9, 2'd2, -1, -1, 1'b0, 1'b1);
        load_pkt(32'h0BB8_1389, 32'h0024_5CF9);
        send_pkt(9, 2'd0, -1, -1, 1'b0, 1'b1);
        load_pkt(32'h0BB8_1388, 32'h0024_5CFB);
        send_pkt(9, 2'd0, -1, -1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_gap_and_err();
        load_pkt(32'h0BB8_1388, 32'h0024_5CFC);
        send_pkt(9, 2'd2, -1, 5, 1'b0, 1'b1);
        send_pkt(9, 2'd2, 4, 3, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL gap_drain got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_short_and_restart();
        load_pkt(32'h0BB8_1388, 32'h0024_5CFB);
        send_pkt(2, 2'd0, -1, -1, 1'b0, 1'b1);
        send_pkt(1, 2'd0, -1, -1, 1'b0, 1'b1);
        send_pkt(5, 2'd0, -1, -1, 1'b1, 1'b1);
        load_pkt(32'h0BB8_1388, 32'h0024_5CFC);
        send_pkt(9, 2'd2, -1, -1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL restart_drain got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_mid_reset();
        load_pkt(32'h0BB8_1388, 32'h0024_5CFC);
        send_pkt(3, 2'd0, -1, -1, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dout_vld, dout_sop, dout_eop, dout_err, flag_sum_err, flag_port_local_err} !== 6'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs got vld=%b sop=%b eop=%b err=%b sum=%b port=%b expected all 0",
                     dout_vld, dout_sop, dout_eop, dout_err, flag_sum_err, flag_port_local_err);
        end
        rst = 1'b0;
        for (int i = 3; i < 9; i++) begin
            din = pkt[i]; din_vld = 1'b1; din_sop = 1'b0; din_eop = (i == 8); din_mty = 2'd0;
            @(negedge clk);
        end
        din_vld = 1'b0; din_eop = 1'b0;
        send_pkt(9, 2'd2, -1, -1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL mid_reset_drain got %0d pending expected 0", sbq.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_ip_local = 32'hC0A8_010A;
        cfg_ip_pc = 32'hC0A8_0109;
        cfg_port_local = 16'h1388;
        din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 2'd0; din_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_good();
        test_wrong_port();
        test_bad_sum();
        test_back_to_back();
        test_gap_and_err();
        test_short_and_restart();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
